// File: rtl/bsg_dmc_pkg.sv
// Shared types and constants for the bsg_dmc controller.
package bsg_dmc_pkg;

  // Refresh scheduler states.
  typedef enum logic [1:0] {
    e_ref_init = 2'd0,
    e_ref_idle = 2'd1,
    e_ref_req  = 2'd2,
    e_ref_rfc  = 2'd3
  } bsg_dmc_refresh_state_e;

  // Refreshes that may be postponed before a request turns urgent.
  localparam int bsg_dmc_max_postpone_gp = 8;

  // Larger of two widths; sizes a register shared between two fields.
  function automatic int bsg_dmc_max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_dmc_interval_timer.sv
// tREFI interval timer: counts up while enabled and emits a registered
// one-cycle tick when the count reaches the limit, then restarts from 0.
// A limit of 0 never ticks. A limit that shrinks below the current count
// ticks on the next cycle instead of wrapping.
module bsg_dmc_interval_timer
  import bsg_dmc_pkg::*;
#(
  parameter int width_p = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [width_p-1:0] limit,
  output logic               tick
);

  logic [width_p-1:0] count_reg;
  logic               tick_reg;

  // Count, compare against the live limit, and clear on each tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (!en) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else if ((limit != '0) && (count_reg >= limit)) begin
      count_reg <= '0;
      tick_reg  <= 1'b1;
    end else begin
      count_reg <= count_reg + width_p'(1);
      tick_reg  <= 1'b0;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/bsg_dmc_refresh_sched.sv
// Refresh scheduler: waits out the power-up window, accrues one owed
// refresh per tREFI interval, requests auto-refresh from the sequencer and
// holds the bank busy for tRFC after each grant. Postponed refreshes are
// capped at max_postpone_p, where the request becomes urgent and ignores
// stall. All outputs come straight from registers.
module bsg_dmc_refresh_sched
  import bsg_dmc_pkg::*;
#(
  parameter int trefi_width_p  = 16,
  parameter int trfc_width_p   = 4,
  parameter int init_width_p   = 16,
  parameter int max_postpone_p = bsg_dmc_max_postpone_gp,
  localparam int owed_width_lp = $clog2(max_postpone_p + 1)
) (
  input  logic                     dfi_clk_1x_i,
  input  logic                     dfi_rst_i,
  input  logic [trefi_width_p-1:0] trefi_i,
  input  logic [trfc_width_p-1:0]  trfc_i,
  input  logic [init_width_p-1:0]  init_cycles_i,
  input  logic                     stall_i,
  output logic                     ref_req_o,
  input  logic                     ref_ack_i,
  output logic                     ref_urgent_o,
  output logic                     ref_busy_o,
  output logic                     init_done_o,
  output logic [owed_width_lp-1:0] owed_o,
  output logic                     overflow_o
);

  // One down-counter serves both the init wait and the tRFC window.
  localparam int cnt_width_lp = bsg_dmc_max_width(init_width_p, trfc_width_p);
  localparam logic [owed_width_lp-1:0] owed_max_lp = owed_width_lp'(max_postpone_p);

  bsg_dmc_refresh_state_e    state_reg;
  logic [cnt_width_lp-1:0]   cnt_reg;
  logic [cnt_width_lp-1:0]   init_count;
  logic                      init_load_reg;
  logic                      init_done_reg;
  logic [owed_width_lp-1:0]  owed_reg;
  logic                      overflow_reg;
  logic                      tick;
  logic                      ack_fire;
  logic                      urgent;

  // Only an ack seen while requesting counts as a grant.
  assign ack_fire = (state_reg == e_ref_req) && ref_ack_i;
  assign urgent   = (owed_reg == owed_max_lp);

  bsg_dmc_interval_timer #(
    .width_p(trefi_width_p)
  ) interval_timer (
    .clk   (dfi_clk_1x_i),
    .reset (dfi_rst_i),
    .en    (state_reg != e_ref_init),
    .limit (trefi_i),
    .tick  (tick)
  );

  // On the first INIT cycle the counter behaves as if already loaded with
  // init_cycles_i, so a zero wait costs exactly one INIT cycle.
  always_comb begin
    init_count = cnt_reg;
    if (init_load_reg) begin
      init_count = cnt_width_lp'(init_cycles_i);
    end
  end

  // Scheduler FSM with the shared down-counter and sticky init-done flag.
  always_ff @(posedge dfi_clk_1x_i or posedge dfi_rst_i) begin
    if (dfi_rst_i) begin
      state_reg     <= e_ref_init;
      cnt_reg       <= '0;
      init_load_reg <= 1'b1;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        e_ref_init: begin
          init_load_reg <= 1'b0;
          if (init_count == '0) begin
            state_reg     <= e_ref_idle;
            init_done_reg <= 1'b1;
          end else begin
            cnt_reg <= init_count - cnt_width_lp'(1);
          end
        end
        e_ref_idle: begin
          if ((owed_reg != '0) && (!stall_i || urgent)) begin
            state_reg <= e_ref_req;
          end
        end
        e_ref_req: begin
          if (ref_ack_i) begin
            state_reg <= e_ref_rfc;
            cnt_reg   <= cnt_width_lp'(trfc_i);
          end
        end
        e_ref_rfc: begin
          if (cnt_reg == '0) begin
            state_reg <= e_ref_idle;
          end else begin
            cnt_reg <= cnt_reg - cnt_width_lp'(1);
          end
        end
        default: state_reg <= e_ref_init;
      endcase
    end
  end

  // Owed refresh count: ticks add, grants subtract, saturating at the cap.
  always_ff @(posedge dfi_clk_1x_i or posedge dfi_rst_i) begin
    if (dfi_rst_i) begin
      owed_reg     <= '0;
      overflow_reg <= 1'b0;
    end else if (tick && !ack_fire) begin
      if (owed_reg == owed_max_lp) begin
        overflow_reg <= 1'b1;
      end else begin
        owed_reg <= owed_reg + owed_width_lp'(1);
      end
    end else if (!tick && ack_fire) begin
      owed_reg <= owed_reg - owed_width_lp'(1);
    end
  end

  assign ref_req_o    = (state_reg == e_ref_req);
  assign ref_busy_o   = (state_reg == e_ref_rfc);
  assign ref_urgent_o = urgent;
  assign init_done_o  = init_done_reg;
  assign owed_o       = owed_reg;
  assign overflow_o   = overflow_reg;

endmodule
